ring_osc_freq_meter: RTL
========================

// Module: ring_osc_freq_meter
// PURPOSE
//  Sits directly downstream of the ring oscillator bank. Muxes one of the seven
//  free-running ring clocks (clk_03..clk_19) into the wb_clk_i domain and counts
//  its rising edges over a programmable window of wb_clk_i cycles.
//  Software uses the count to characterise each ring against the system clock.
//  Ring clocks are treated as asynchronous data; there is no logic in any ring domain.
// PARAMETERS
//  CNT_W        16  width of the edge counter / count output
//  WIN_W        16  width of the window length input
//  SYNC_STAGES   2  flops in the synchroniser on the selected ring clock (>=2)
// PORTS
//  wb_clk_i   in   1          system clock; all logic on its rising edge
//  wb_rst_i   in   1          asynchronous, active-high reset
//  clk_03..clk_19 in 1 each   ring oscillator outputs (7 ports)
//  sel        in   3          ring select: 0..6 = clk_03,05,07,11,13,17,19; 7 = none (const 0)
//  win_len    in   WIN_W      measurement window, in wb_clk_i cycles
//  start      in   1          1-cycle request; accepted only when busy=0
//  busy       out  1          measurement in progress
//  done       out  1          sticky: count/overflow valid; cleared by the next accepted start
//  count      out  CNT_W      rising edges seen in the window (saturating)
//  overflow   out  1          count saturated at all-ones during the window
//  (vccd1/vssd1 inout under USE_POWER_PINS)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, count=0, overflow=0; sync chain and prev-bit = 0.
//  Mux: combinational; output feeds the SYNC_STAGES-deep synchroniser every cycle.
//  Edge detect: prev <= sync_out every cycle; edge = sync_out & ~prev.
//  FSM: IDLE -> SETTLE -> COUNT -> IDLE.
//   IDLE: start=1 at edge T -> capture sel, win_len; clear count/overflow; done=0,
//     busy=1 from T+1; enter SETTLE.
//   SETTLE: exactly SYNC_STAGES+1 cycles; flushes the chain; edges are ignored.
//   COUNT: exactly win_len cycles; each cycle with edge=1 increments count;
//     at all-ones count holds and overflow sets (sticky until next start).
//   COUNT end: next cycle busy=0, done=1, state=IDLE; count holds.
//  win_len=0: COUNT is skipped; done=1 right after SETTLE with count=0.
//  start while busy=1: ignored; captured sel/win_len do not change.
//  sel/win_len changes while busy: no effect on the running measurement.
//  start in the same cycle done rises: not possible (busy=1 in that cycle), so ignored.
//  Reset mid-operation: immediate return to reset values; no done pulse.
//  Accuracy: exact to +/-1 edge only when ring freq < wb_clk_i/2; faster rings alias.
// TESTING
//  1 Reset release, no start -> busy=0, done=0, count=0, overflow=0 for 50 cycles.
//  2 clk_07 toggled every 4 wb cycles (period 8), sel=2, win_len=800, start ->
//    busy for 3+800 cycles, then done=1, count in 99..101, overflow=0.
//  3 CNT_W=4 build, clk_03 period 4, sel=0, win_len=100 -> done=1, count=15, overflow=1.
//  4 sel=7 and win_len=0 (separate runs) -> done=1 with count=0; in the
//    win_len=0 run done rises SYNC_STAGES+2 cycles after start.
//  5 start pulsed again mid-count with sel changed -> ignored; result matches the
//    first sel; then a start after done -> done=0 next cycle, new result.
//  6 wb_rst_i asserted mid-COUNT for 1 cycle -> all outputs 0 while asserted and after;
//    a fresh start then completes normally.

Source files
------------

// File: rtl/ring_osc_freq_meter_if.sv
// Control/result bundle for the ring oscillator frequency meter:
// software-side request fields in, measurement status and result out.
`timescale 1ns/100ps
interface ring_osc_freq_meter_if #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);
  logic [2:0]       sel;
  logic [WIN_W-1:0] win_len;
  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output sel, win_len, start,
    input  busy, done, count, overflow
  );

  modport slave (
    input  sel, win_len, start,
    output busy, done, count, overflow
  );
endinterface

// File: rtl/ring_osc_freq_meter.sv
// Counts rising edges of one selected ring oscillator, sampled as asynchronous
// data in the wb_clk_i domain, over a programmable window of wb_clk_i cycles.
`timescale 1ns/100ps
module ring_osc_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
`ifdef USE_POWER_PINS
  inout wire vccd1,
  inout wire vssd1,
`endif
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  clk_03,
  input  logic                  clk_05,
  input  logic                  clk_07,
  input  logic                  clk_11,
  input  logic                  clk_13,
  input  logic                  clk_17,
  input  logic                  clk_19,
  ring_osc_freq_meter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT} state_t;

  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SYNC_STAGES);

  state_t                 state;
  logic [2:0]             sel_q;
  logic [WIN_W-1:0]       win_q;
  logic [WIN_W-1:0]       tmr;
  logic                   ring_mux;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;
  logic                   rise_p1;
  logic [CNT_W:0]         inc;

  // Returns {saturated, next}; holds at all-ones instead of wrapping.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return {1'b1, c};
    else    return {1'b0, c + CNT_W'(1)};
  endfunction

  always_comb begin
    ring_mux = 1'b0;
    case (sel_q)
      3'd0:    ring_mux = clk_03;
      3'd1:    ring_mux = clk_05;
      3'd2:    ring_mux = clk_07;
      3'd3:    ring_mux = clk_11;
      3'd4:    ring_mux = clk_13;
      3'd5:    ring_mux = clk_17;
      3'd6:    ring_mux = clk_19;
      default: ring_mux = 1'b0;
    endcase
  end

  assign rise_p1 = sync_p0[SYNC_STAGES-1] & ~prev_p1;
  assign inc     = sat_inc(bus.count);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_p0      <= '0;
      prev_p1      <= 1'b0;
      state        <= IDLE;
      sel_q        <= 3'd7;
      win_q        <= '0;
      tmr          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.count    <= '0;
      bus.overflow <= 1'b0;
    end else begin
      // stage p0: synchroniser on the muxed ring; stage p1: edge history
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], ring_mux};
      prev_p1 <= sync_p0[SYNC_STAGES-1];

      case (state)
        IDLE: begin
          if (bus.start) begin
            sel_q        <= bus.sel;
            win_q        <= bus.win_len;
            tmr          <= SETTLE_LAST;
            bus.count    <= '0;
            bus.overflow <= 1'b0;
            bus.done     <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= SETTLE;
          end
        end
        // Samples of the previous ring still in the chain are discarded here.
        SETTLE: begin
          if (tmr == '0) begin
            if (win_q == '0) begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state    <= IDLE;
            end else begin
              tmr   <= win_q - WIN_W'(1);
              state <= COUNT;
            end
          end else begin
            tmr <= tmr - WIN_W'(1);
          end
        end
        COUNT: begin
          if (rise_p1) begin
            bus.count <= inc[CNT_W-1:0];
            if (inc[CNT_W]) bus.overflow <= 1'b1;
          end
          if (tmr == '0) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= IDLE;
          end else begin
            tmr <= tmr - WIN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
